johnson_seq_ctrl: RTL and testbench

- Run controller for the team's 4-bit shift-register counters.
- Owns the counter register and sequences it in ring or Johnson (twisted-ring) mode, shifting in either direction at a programmable prescaled rate.
- Runs for a programmed number of steps or continuously; provides a start/busy/done handshake, abort, and illegal-state self-correction.
- Sits between a host/sequencer and downstream phase/timing logic that consumes q/qbar.

---
 rtl/johnson_seq_ctrl_if.sv | 30 +++
 rtl/johnson_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Host-side control and counter-state bundle for johnson_seq_ctrl.
// The host drives the run request and its parameters; the controller returns the counter state and handshake pulses.
interface johnson_seq_ctrl_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned STEP_W     = 8
);
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic                  dir;
  logic [PRESCALE_W-1:0] prescale;
  logic [STEP_W-1:0]     steps;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;
  logic                  done;
  logic                  step_strobe;
  logic                  err;

  modport master (
    output start, stop, mode, dir, prescale, steps,
    input  q, qbar, busy, done, step_strobe, err
  );

  modport slave (
    input  start, stop, mode, dir, prescale, steps,
    output q, qbar, busy, done, step_strobe, err
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a ring / Johnson shift-register counter.
// Supports a prescaled step rate, counted or continuous runs, abort, and illegal-state self-correction.
module johnson_seq_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned STEP_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  johnson_seq_ctrl_if.slave  bus
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_RUN     = 1'b1;
  localparam logic [WIDTH-1:0] RING_SEED = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]            state_q, state_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [STEP_W-1:0]     scnt_q, scnt_d;
  logic [STEP_W-1:0]     steps_q, steps_d;
  logic                  mode_q, mode_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  strobe_q, strobe_d;
  logic                  err_q, err_d;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return m ? '0 : RING_SEED;
  endfunction

  // Johnson feeds back the inverted end bit; ring feeds it back unchanged.
  function automatic logic [WIDTH-1:0] shift_of(input logic m, input logic d,
                                                input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (!d) r = {(m ? ~v[0] : v[0]), v[WIDTH-1:1]};
    else    r = {v[WIDTH-2:0], (m ? ~v[WIDTH-1] : v[WIDTH-1])};
    return r;
  endfunction

  function automatic logic legal_of(input logic m, input logic [WIDTH-1:0] v);
    int unsigned ones;
    int unsigned flips;
    ones  = 0;
    flips = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones  = ones + 32'(v[i]);
      flips = flips + 32'(v[i] ^ v[(i + 1) % int'(WIDTH)]);
    end
    return m ? ((flips == 0) || (flips == 2)) : (ones == 1);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    logic step_c;
    logic last_c;
    state_d  = state_q;
    q_d      = q_q;
    pcnt_d   = pcnt_q;
    presc_d  = presc_q;
    scnt_d   = scnt_q;
    steps_d  = steps_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          mode_d  = bus.mode;
          dir_d   = bus.dir;
          presc_d = bus.prescale;
          steps_d = bus.steps;
          q_d     = seed_of(bus.mode);
          pcnt_d  = '0;
          scnt_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_c = (pcnt_q == presc_q);
        pcnt_d = step_c ? '0 : pcnt_q + PRESCALE_W'(1);
        if (step_c) begin
          strobe_d = 1'b1;
          if (legal_of(mode_q, q_q)) begin
            q_d = shift_of(mode_q, dir_q, q_q);
          end else begin
            q_d   = seed_of(mode_q);
            err_d = 1'b1;
          end
          if (steps_q != '0) begin
            scnt_d = scnt_q + STEP_W'(1);
            last_c = (scnt_d == steps_q);
          end
        end
        // Completion outranks a coincident abort so done still pulses.
        if (last_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.stop) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      pcnt_q   <= '0;
      presc_q  <= '0;
      scnt_q   <= '0;
      steps_q  <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      pcnt_q   <= pcnt_d;
      presc_q  <= presc_d;
      scnt_q   <= scnt_d;
      steps_q  <= steps_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.qbar        = ~q_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.step_strobe = strobe_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: per-cycle vector table plus hand sequences
// for illegal-state correction and mid-run reset.
module tb_johnson_seq_ctrl;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [7:0] pre;
    logic [7:0] steps;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       strb;
    logic       err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  logic [3:0] jr [8];
  logic [3:0] rl [5];

  johnson_seq_ctrl_if #(.WIDTH(4), .PRESCALE_W(8), .STEP_W(8)) bus ();

  johnson_seq_ctrl #(.WIDTH(4), .PRESCALE_W(8), .STEP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic st, input logic sp, input logic m, input logic d,
                              input logic [7:0] pre, input logic [7:0] stp, input logic [3:0] eq,
                              input logic eb, input logic ed, input logic es, input logic ee);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = m; v.dir = d; v.pre = pre; v.steps = stp;
    v.q = eq; v.busy = eb; v.done = ed; v.strb = es; v.err = ee;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eq, input logic eb,
                     input logic ed, input logic es, input logic ee);
    logic [11:0] got;
    logic [11:0] exp;
    got = {bus.q, bus.qbar, bus.busy, bus.done, bus.step_strobe, bus.err};
    exp = {eq, ~eq, eb, ed, es, ee};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got q=%b qbar=%b busy=%b done=%b strobe=%b err=%b, expected q=%b qbar=%b busy=%b done=%b strobe=%b err=%b",
               nm, bus.q, bus.qbar, bus.busy, bus.done, bus.step_strobe, bus.err,
               eq, ~eq, eb, ed, es, ee);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic m, input logic d,
                       input logic [7:0] pre, input logic [7:0] stp);
    bus.start = st; bus.stop = sp; bus.mode = m; bus.dir = d;
    bus.prescale = pre; bus.steps = stp;
  endtask

  initial begin
    logic [3:0] cur;
    int         n;
    logic       seen;
    n_tests = 0;
    n_fail  = 0;
    jr[0] = 4'b1000; jr[1] = 4'b1100; jr[2] = 4'b1110; jr[3] = 4'b1111;
    jr[4] = 4'b0111; jr[5] = 4'b0011; jr[6] = 4'b0001; jr[7] = 4'b0000;
    rl[0] = 4'b0001; rl[1] = 4'b0010; rl[2] = 4'b0100; rl[3] = 4'b1000; rl[4] = 4'b0001;

    // Johnson right, every clock, 8 steps
    add(1, 0, 1, 0, 8'd0, 8'd8, 4'b0000, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 8'd0, 8'd0, jr[k], k != 7, k == 7, 1, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0000, 0, 0, 0, 0);

    // Ring left, prescale 2, 5 steps; a start pulse mid-run must be ignored
    add(1, 0, 0, 1, 8'd2, 8'd5, 4'b1000, 1, 0, 0, 0);
    cur = 4'b1000;
    for (int e = 1; e <= 15; e++) begin
      if (e % 3 == 0) cur = rl[e / 3 - 1];
      add(e == 4, 0, 1, 0, 8'd0, 8'd1, cur, e != 15, e == 15, e % 3 == 0, 0);
    end
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0001, 0, 0, 0, 0);
    // start with stop in IDLE: nothing happens
    add(1, 1, 1, 0, 8'd0, 8'd8, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0001, 0, 0, 0, 0);

    // Continuous Johnson, prescale 1, stop after 20 clocks
    add(1, 0, 1, 0, 8'd1, 8'd0, 4'b0000, 1, 0, 0, 0);
    cur = 4'b0000;
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e % 2 == 0) begin
        cur = jr[n % 8];
        n++;
      end
      add(0, 0, 0, 0, 8'd0, 8'd0, cur, 1, 0, e % 2 == 0, 0);
    end
    add(0, 1, 0, 0, 8'd0, 8'd0, 4'b1100, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b1100, 0, 0, 0, 0);

    // Continuous ring right: stop on a step applies the step, no done
    add(1, 0, 0, 0, 8'd0, 8'd0, 4'b1000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0100, 1, 0, 1, 0);
    add(0, 1, 0, 0, 8'd0, 8'd0, 4'b0010, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0010, 0, 0, 0, 0);

    // Johnson left, 3 steps; stop on final step still completes with done
    add(1, 0, 1, 1, 8'd0, 8'd3, 4'b0000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0001, 1, 0, 1, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0011, 1, 0, 1, 0);
    add(0, 1, 0, 0, 8'd0, 8'd0, 4'b0111, 0, 1, 1, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0111, 0, 0, 0, 0);

    // Single-step run
    add(1, 0, 0, 0, 8'd0, 8'd1, 4'b1000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0100, 0, 1, 1, 0);
    add(0, 0, 0, 0, 8'd0, 8'd0, 4'b0100, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    #12;
    chk("reset_state", 4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dir, vecs[i].pre, vecs[i].steps);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].strb, vecs[i].err);
    end

    // Illegal ring state mid-run: ring right, prescale 3, 6 steps
    drive(1, 0, 0, 0, 8'd3, 8'd6);
    tick();
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    for (int e = 1; e <= 5; e++) tick();
    chk("fix_pre", 4'b0100, 1, 0, 0, 0);
    force dut.q_q = 4'b1010;
    tick();
    tick();
    release dut.q_q;
    tick();
    chk("fix_step", 4'b1000, 1, 0, 1, 1);
    tick();
    chk("fix_err_drop", 4'b1000, 1, 0, 0, 0);
    for (int e = 10; e <= 12; e++) tick();
    chk("fix_resume1", 4'b0100, 1, 0, 1, 0);
    for (int e = 13; e <= 16; e++) tick();
    chk("fix_resume2", 4'b0010, 1, 0, 1, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = bus.done;
    end
    if (seen) chk("fix_done", 4'b1000, 0, 1, 1, 0);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL fix_done_timeout: got no done within 20 cycles, expected done");
    end

    // Reset mid-run, prescale 5
    drive(1, 0, 1, 0, 8'd5, 8'd0);
    tick();
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    for (int e = 1; e <= 8; e++) tick();
    chk("rst_prerun", 4'b1000, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("rst_idle%0d", c), 4'b0000, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
